dmem_responder: RTL and testbench

- Memory-side responder for the load/store requests the control path raises through mem_wen, mem_ren and mem_mask.
- Accepts one request at a time over a valid/ready handshake and services it against an internal 64-bit-word data array after a fixed programmable latency.
- Returns right-aligned, zero-extended read data plus an error flag over a second valid/ready handshake.
- Sits between the core datapath and the data store of the LemonPC npc.

---
 rtl/dmem_responder.sv | 178 +++++++++++++++++
 tb/tb_dmem_responder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for core load/store requests.
// One request at a time over valid/ready; each request is serviced against
// an internal 64-bit-word array after LATENCY cycles. The read data comes
// back right-aligned and zero-extended, with an error flag.
// Optional build macro: DMEM_MISALIGN_CHECK_EN.
//   Defined:   a lane that is not a multiple of the access size faults.
//   Undefined: the lane bits below the access size are forced to zero.
module dmem_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_wen,
  input  logic        mem_ren,
  input  logic [7:0]  mem_mask,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;

  // request fields captured at acceptance; the core may change its inputs afterwards
  logic        wen_q;
  logic        ren_q;
  logic [7:0]  mask_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;

  logic [63:0] mem [DEPTH_WORDS];

  logic [63:0]      off;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [2:0]       lane;
  logic [2:0]       lane_eff;
  logic [2:0]       align;
  logic             mask_ok;
  logic             misalign;
  logic             access;
  logic             fault;
  logic [7:0]       be;
  logic [63:0]      bit_mask;
  logic [63:0]      wdata_sh;
  logic [63:0]      rd_word;
  logic [63:0]      rd_val;
  logic             commit;

  // address decode: the word index and byte lane come from the offset to BASE_ADDR
  always_comb begin
    off      = addr_q - BASE_ADDR;
    idx      = off[IDX_W+2:3];
    lane     = off[2:0];
    in_range = (addr_q >= BASE_ADDR) && (off[63:IDX_W+3] == '0);
  end

  // size decode: a legal mask sets align, and align keeps only the lane bits
  // that stay meaningful at that access size
  always_comb begin
    mask_ok = 1'b1;
    align   = 3'b111;
    case (mask_q)
      8'h01:   align = 3'b111;
      8'h03:   align = 3'b110;
      8'h0F:   align = 3'b100;
      8'hFF:   align = 3'b000;
      default: mask_ok = 1'b0;
    endcase
  end

  // lane selection: the misaligned lane either faults or is rounded down
  always_comb begin
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = mask_ok && ((lane & ~align) != 3'b000);
    lane_eff = lane;
`else
    misalign = 1'b0;
    lane_eff = lane & align;
`endif
  end

  // fault and commit qualification; a request with no flags never touches the array
  always_comb begin
    access = wen_q | ren_q;
    fault  = access && (!in_range || !mask_ok || misalign);
    commit = (state == BUSY) && (cnt == 4'd0) && wen_q && !fault;
  end

  // byte enables, shifted store data and right-aligned, masked read data
  always_comb begin
    be       = mask_q << lane_eff;
    wdata_sh = wdata_q << {lane_eff, 3'b000};
    for (int b = 0; b < 8; b++) begin
      bit_mask[8*b +: 8] = {8{mask_q[b]}};
    end
    rd_word  = mem[idx];
    rd_val   = (rd_word >> {lane_eff, 3'b000}) & bit_mask;
  end

  // array write port; no reset, so the contents survive rst_n
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // control FSM: accept, count down the latency, then hold the response
  // until the core takes it. The read uses the pre-write word because the
  // write lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      rdata      <= '0;
      resp_err   <= 1'b0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      mask_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wen_q     <= mem_wen;
            ren_q     <= mem_ren;
            mask_q    <= mem_mask;
            addr_q    <= addr;
            wdata_q   <= wdata;
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rdata      <= (ren_q && !fault) ? rd_val : 64'd0;
            resp_err   <= fault;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Expected responses go into a
// scoreboard queue when each request is issued and are popped for comparison
// when the response shows up.
module tb_dmem_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        mem_wen;
  logic        mem_ren;
  logic [7:0]  mem_mask;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] rdata;
  logic        resp_err;

  int total;
  int bad;

  logic [64:0] sb[$];

  typedef struct packed {
    logic        w;
    logic        r;
    logic [7:0]  m;
    logic [63:0] a;
    logic [63:0] wd;
    logic [63:0] er;
    logic        ee;
  } step_t;

  dmem_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_mask  (mem_mask),
    .addr      (addr),
    .wdata     (wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .rdata     (rdata),
    .resp_err  (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic step_t mk(input logic w, input logic r, input logic [7:0] m,
                               input logic [63:0] a, input logic [63:0] wd,
                               input logic [63:0] er, input logic ee);
    step_t s;
    s.w = w; s.r = r; s.m = m; s.a = a; s.wd = wd; s.er = er; s.ee = ee;
    return s;
  endfunction

  // drives one request, measures acceptance-to-response latency and completes the handshake
  task automatic run_req(input step_t s, output int lat, output logic [63:0] rd, output logic er);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    mem_wen   = s.w;
    mem_ren   = s.r;
    mem_mask  = s.m;
    addr      = s.a;
    wdata     = s.wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) lat = -1;
    rd = rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset resp_valid: got %b want 0", resp_valid); end
    total++; if (rdata !== 64'd0) begin bad++; $display("FAIL reset rdata: got %h want 0", rdata); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset resp_err: got %b want 0", resp_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_double();
    step_t st[$];
    int lat; logic [63:0] rd; logic er; logic [64:0] e;
    st.push_back(mk(1, 0, 8'hFF, 64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 64'd0, 0));
    st.push_back(mk(0, 1, 8'hFF, 64'h8000_0010, 64'd0, 64'hDEAD_BEEF_0123_4567, 0));
    foreach (st[i]) begin
      sb.push_back({st[i].ee, st[i].er});
      run_req(st[i], lat, rd, er);
      e = sb.pop_front();
      total++; if (lat !== LAT) begin bad++; $display("FAIL double[%0d] latency: got %0d want %0d", i, lat, LAT); end
      total++; if (rd !== e[63:0]) begin bad++; $display("FAIL double[%0d] rdata: got %h want %h", i, rd, e[63:0]); end
      total++; if (er !== e[64]) begin bad++; $display("FAIL double[%0d] resp_err: got %b want %b", i, er, e[64]); end
    end
  endtask

  task automatic test_byte_lanes();
    step_t st[$];
    int lat; logic [63:0] rd; logic er; logic [64:0] e;
    st.push_back(mk(1, 0, 8'hFF, 64'h8000_0010, 64'd0, 64'd0, 0));
    st.push_back(mk(1, 0, 8'h01, 64'h8000_0013, 64'h0000_0000_0000_00AB, 64'd0, 0));
    st.push_back(mk(0, 1, 8'hFF, 64'h8000_0010, 64'd0, 64'h0000_0000_AB00_0000, 0));
    st.push_back(mk(0, 1, 8'h03, 64'h8000_0012, 64'd0, 64'h0000_0000_0000_AB00, 0));
    st.push_back(mk(0, 1, 8'h01, 64'h8000_0013, 64'd0, 64'h0000_0000_0000_00AB, 0));
    st.push_back(mk(1, 0, 8'h03, 64'h8000_0016, 64'hFFFF_FFFF_FFFF_1234, 64'd0, 0));
    st.push_back(mk(0, 1, 8'hFF, 64'h8000_0010, 64'd0, 64'h1234_0000_AB00_0000, 0));
    foreach (st[i]) begin
      sb.push_back({st[i].ee, st[i].er});
      run_req(st[i], lat, rd, er);
      e = sb.pop_front();
      total++; if (lat !== LAT) begin bad++; $display("FAIL lanes[%0d] latency: got %0d want %0d", i, lat, LAT); end
      total++; if (rd !== e[63:0]) begin bad++; $display("FAIL lanes[%0d] rdata: got %h want %h", i, rd, e[63:0]); end
      total++; if (er !== e[64]) begin bad++; $display("FAIL lanes[%0d] resp_err: got %b want %b", i, er, e[64]); end
    end
  endtask

  task automatic test_errors();
    step_t st[$];
    int lat; logic [63:0] rd; logic er; logic [64:0] e;
    logic [63:0] top;
    top = BASE + 64'(8 * DEPTH);
    st.push_back(mk(1, 0, 8'hFF, BASE, 64'h1111_1111_1111_1111, 64'd0, 0));
    st.push_back(mk(1, 0, 8'hFF, top - 64'd8, 64'h7777_6666_5555_4444, 64'd0, 0));
    st.push_back(mk(0, 1, 8'hFF, 64'h7FFF_FFF8, 64'd0, 64'd0, 1));
    st.push_back(mk(0, 1, 8'hFF, top, 64'd0, 64'd0, 1));
    st.push_back(mk(1, 0, 8'hFF, top, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1));
    st.push_back(mk(1, 1, 8'hFF, 64'h7FFF_FFF8, 64'hEEEE_EEEE_EEEE_EEEE, 64'd0, 1));
    st.push_back(mk(1, 0, 8'h07, BASE, 64'h2222_2222_2222_2222, 64'd0, 1));
    st.push_back(mk(0, 1, 8'h07, BASE, 64'd0, 64'd0, 1));
    st.push_back(mk(0, 0, 8'h07, 64'h7000_0000, 64'h3333_3333_3333_3333, 64'd0, 0));
    st.push_back(mk(0, 1, 8'hFF, BASE, 64'd0, 64'h1111_1111_1111_1111, 0));
    st.push_back(mk(0, 1, 8'hFF, top - 64'd8, 64'd0, 64'h7777_6666_5555_4444, 0));
    foreach (st[i]) begin
      sb.push_back({st[i].ee, st[i].er});
      run_req(st[i], lat, rd, er);
      e = sb.pop_front();
      total++; if (lat !== LAT) begin bad++; $display("FAIL errors[%0d] latency: got %0d want %0d", i, lat, LAT); end
      total++; if (rd !== e[63:0]) begin bad++; $display("FAIL errors[%0d] rdata: got %h want %h", i, rd, e[63:0]); end
      total++; if (er !== e[64]) begin bad++; $display("FAIL errors[%0d] resp_err: got %b want %b", i, er, e[64]); end
    end
  endtask

  task automatic test_read_before_write();
    step_t st[$];
    int lat; logic [63:0] rd; logic er; logic [64:0] e;
    st.push_back(mk(1, 0, 8'hFF, 64'h8000_0050, 64'hA5A5_A5A5_A5A5_A5A5, 64'd0, 0));
    st.push_back(mk(1, 1, 8'h0F, 64'h8000_0050, 64'h0000_0000_CAFE_F00D, 64'h0000_0000_A5A5_A5A5, 0));
    st.push_back(mk(0, 1, 8'hFF, 64'h8000_0050, 64'd0, 64'hA5A5_A5A5_CAFE_F00D, 0));
    foreach (st[i]) begin
      sb.push_back({st[i].ee, st[i].er});
      run_req(st[i], lat, rd, er);
      e = sb.pop_front();
      total++; if (rd !== e[63:0]) begin bad++; $display("FAIL rbw[%0d] rdata: got %h want %h", i, rd, e[63:0]); end
      total++; if (er !== e[64]) begin bad++; $display("FAIL rbw[%0d] resp_err: got %b want %b", i, er, e[64]); end
    end
  endtask

  task automatic test_misalign();
    step_t st[$];
    int lat; logic [63:0] rd; logic er; logic [64:0] e;
    st.push_back(mk(1, 0, 8'hFF, 64'h8000_0020, 64'd0, 64'd0, 0));
`ifdef DMEM_MISALIGN_CHECK_EN
    st.push_back(mk(1, 0, 8'h0F, 64'h8000_0022, 64'h0000_0000_1122_3344, 64'd0, 1));
    st.push_back(mk(0, 1, 8'hFF, 64'h8000_0020, 64'd0, 64'd0, 0));
    st.push_back(mk(0, 1, 8'hFF, 64'h8000_0003, 64'd0, 64'd0, 1));
    st.push_back(mk(0, 1, 8'h03, 64'h8000_0001, 64'd0, 64'd0, 1));
`else
    st.push_back(mk(1, 0, 8'h0F, 64'h8000_0022, 64'h0000_0000_1122_3344, 64'd0, 0));
    st.push_back(mk(0, 1, 8'hFF, 64'h8000_0020, 64'd0, 64'h0000_0000_1122_3344, 0));
    st.push_back(mk(0, 1, 8'hFF, 64'h8000_0003, 64'd0, 64'h1111_1111_1111_1111, 0));
    st.push_back(mk(0, 1, 8'h03, 64'h8000_0021, 64'd0, 64'h0000_0000_0000_3344, 0));
`endif
    st.push_back(mk(0, 1, 8'h03, 64'h8000_0000, 64'd0, 64'h0000_0000_0000_1111, 0));
    foreach (st[i]) begin
      sb.push_back({st[i].ee, st[i].er});
      run_req(st[i], lat, rd, er);
      e = sb.pop_front();
      total++; if (rd !== e[63:0]) begin bad++; $display("FAIL misalign[%0d] rdata: got %h want %h", i, rd, e[63:0]); end
      total++; if (er !== e[64]) begin bad++; $display("FAIL misalign[%0d] resp_err: got %b want %b", i, er, e[64]); end
    end
  endtask

  task automatic test_back_pressure();
    int lat; logic [63:0] rd; logic er; logic [64:0] e;
    int n;
    sb.push_back({1'b0, 64'd0});
    run_req(mk(1, 0, 8'hFF, 64'h8000_0040, 64'h0123_4567_89AB_CDEF, 64'd0, 0), lat, rd, er);
    e = sb.pop_front();
    total++; if (rd !== e[63:0] || er !== e[64]) begin bad++; $display("FAIL stall_store: got %h/%b want %h/%b", rd, er, e[63:0], e[64]); end

    sb.push_back({1'b0, 64'h0123_4567_89AB_CDEF});
    @(negedge clk);
    req_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; mem_mask = 8'hFF; addr = 64'h8000_0040;
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_ren = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    total++; if (n !== LAT) begin bad++; $display("FAIL stall latency: got %0d want %0d", n, LAT); end
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = ~req_valid;
      mem_wen   = 1'b1;
      mem_ren   = ~mem_ren;
      addr      = addr ^ 64'h8;
      wdata     = 64'hBAD0_BAD0_BAD0_BAD0;
      #1;
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL stall[%0d] resp_valid: got %b want 1", i, resp_valid); end
      total++; if (rdata !== e[63:0]) begin bad++; $display("FAIL stall[%0d] rdata: got %h want %h", i, rdata, e[63:0]); end
      total++; if (resp_err !== e[64]) begin bad++; $display("FAIL stall[%0d] resp_err: got %b want %b", i, resp_err, e[64]); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL stall[%0d] req_ready: got %b want 0", i, req_ready); end
    end

    sb.push_back({1'b0, 64'h0000_0000_89AB_CDEF});
    @(negedge clk);
    req_valid = 1'b1; mem_wen = 1'b0; mem_ren = 1'b1; mem_mask = 8'h0F; addr = 64'h8000_0040;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL handshake resp_valid: got %b want 0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL handshake req_ready: got %b want 1", req_ready); end
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_ren = 1'b0;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL accept_after req_ready: got %b want 0", req_ready); end
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    e = sb.pop_front();
    total++; if (n !== LAT) begin bad++; $display("FAIL accept_after latency: got %0d want %0d", n, LAT); end
    total++; if (rdata !== e[63:0]) begin bad++; $display("FAIL accept_after rdata: got %h want %h", rdata, e[63:0]); end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_busy();
    int lat; logic [63:0] rd; logic er; logic [64:0] e;
    run_req(mk(1, 0, 8'hFF, 64'h8000_0030, 64'h5555_AAAA_0000_FFFF, 64'd0, 0), lat, rd, er);
    sb.push_back({1'b0, 64'h5555_AAAA_0000_FFFF});
    run_req(mk(0, 1, 8'hFF, 64'h8000_0030, 64'd0, 64'd0, 0), lat, rd, er);
    e = sb.pop_front();
    total++; if (rd !== e[63:0]) begin bad++; $display("FAIL rst_busy preload: got %h want %h", rd, e[63:0]); end

    @(negedge clk);
    req_valid = 1'b1; mem_wen = 1'b1; mem_ren = 1'b0; mem_mask = 8'hFF;
    addr = 64'h8000_0030; wdata = 64'h0BAD_0BAD_0BAD_0BAD;
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_wen = 1'b0;
    @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_busy in_busy req_ready: got %b want 0", req_ready); end
    rst_n = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_busy req_ready: got %b want 1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_busy resp_valid: got %b want 0", resp_valid); end
    total++; if (rdata !== 64'd0) begin bad++; $display("FAIL rst_busy rdata: got %h want 0", rdata); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_busy resp_err: got %b want 0", resp_err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    sb.push_back({1'b0, 64'h5555_AAAA_0000_FFFF});
    run_req(mk(0, 1, 8'hFF, 64'h8000_0030, 64'd0, 64'd0, 0), lat, rd, er);
    e = sb.pop_front();
    total++; if (lat !== LAT) begin bad++; $display("FAIL rst_busy reload latency: got %0d want %0d", lat, LAT); end
    total++; if (rd !== e[63:0]) begin bad++; $display("FAIL rst_busy reload rdata: got %h want %h", rd, e[63:0]); end
    total++; if (er !== e[64]) begin bad++; $display("FAIL rst_busy reload resp_err: got %b want %b", er, e[64]); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    mem_wen    = 1'b0;
    mem_ren    = 1'b0;
    mem_mask   = 8'h00;
    addr       = 64'd0;
    wdata      = 64'd0;
    resp_ready = 1'b0;

    test_reset();
    test_double();
    test_byte_lanes();
    test_errors();
    test_read_before_write();
    test_misalign();
    test_back_pressure();
    test_reset_busy();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
